// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the instruction fetch unit
package core_pkg;

  typedef enum logic [1:0] {
    FEXC_NONE       = 2'd0,
    FEXC_MISALIGNED = 2'd1,
    FEXC_ACCESS     = 2'd2
  } fetch_exc_e;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    DISCARD  = 2'd2,
    HALT     = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    fetch_exc_e  exc;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// rtl/core_fetch_fifo.sv - instruction buffer between memory responses and decode
module core_fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer/count update; flush drops everything and wins over push/pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: reads are qualified by count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/core_fetch.sv
// rtl/core_fetch.sv - instruction fetch: one outstanding memory request, buffered to decode
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output fetch_exc_e  if_exc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;     // address of a request held across cycles
  logic         req_hold_q, req_hold_d;     // request asserted but not yet accepted
  logic [31:0]  rsp_pc_q, rsp_pc_d;         // PC of the accepted request
  logic         mis_pend_q, mis_pend_d;     // misaligned entry still to be pushed
  logic         halt_after_q, halt_after_d; // discard ends in HALT (misaligned target)

  logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [31:0]                  occ;
  fetch_entry_t                 push_entry, head_entry;
  logic                         push;
  logic                         hs, waiting, misaligned, can_fetch, can_chain;

  assign occ        = 32'(fifo_count);
  assign hs         = imem_req_valid & imem_req_ready;
  assign waiting    = (state_q == WAIT_RSP) | ((state_q == DISCARD) & ~req_hold_q);
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign can_fetch  = (state_q == FETCH) & (occ < FIFO_DEPTH);
  // The returning response occupies a slot, so chain only if one more still fits
  assign can_chain  = (state_q == WAIT_RSP) & imem_rsp_valid & ~imem_rsp_err &
                      ((occ + 32'd1) < FIFO_DEPTH);

  // A held request stays up regardless of redirects; new ones never start on a redirect
  assign imem_req_valid = rst_n & (req_hold_q | (~redirect_valid & (can_fetch | can_chain)));
  assign imem_req_addr  = req_hold_q ? req_addr_q : fetch_pc_q;

  // Next-state, fetch PC and buffer push decisions; redirect overrides everything
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    req_hold_d       = imem_req_valid & ~hs;
    req_addr_d       = imem_req_addr;
    rsp_pc_d         = hs ? imem_req_addr : rsp_pc_q;
    mis_pend_d       = mis_pend_q;
    halt_after_d     = halt_after_q;
    push             = 1'b0;
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = rsp_pc_q;
    push_entry.exc   = FEXC_NONE;

    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      mis_pend_d   = misaligned;
      halt_after_d = misaligned;
      if (imem_req_valid | (waiting & ~imem_rsp_valid)) begin
        state_d = DISCARD;
      end else begin
        state_d = misaligned ? HALT : FETCH;
      end
    end else begin
      if (mis_pend_q & fifo_empty) begin
        push             = 1'b1;
        push_entry.instr = 32'h0;
        push_entry.pc    = fetch_pc_q;
        push_entry.exc   = FEXC_MISALIGNED;
        mis_pend_d       = 1'b0;
      end
      unique case (state_q)
        FETCH: begin
          if (hs) begin
            state_d    = WAIT_RSP;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            push = 1'b1;
            if (imem_rsp_err) begin
              push_entry.exc = FEXC_ACCESS;
              state_d        = HALT;
            end else if (hs) begin
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = FETCH;
            end
          end
        end
        DISCARD: begin
          // A held stale request must still complete its handshake before we
          // wait for (and drop) its response.
          if (!req_hold_q && imem_rsp_valid) begin
            state_d = halt_after_q ? HALT : FETCH;
          end
        end
        HALT: ;
        default: state_d = FETCH;
      endcase
    end
  end

  // Fetch state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_VEC;
      req_addr_q   <= RESET_VEC;
      req_hold_q   <= 1'b0;
      rsp_pc_q     <= RESET_VEC;
      mis_pend_q   <= 1'b0;
      halt_after_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      req_hold_q   <= req_hold_d;
      rsp_pc_q     <= rsp_pc_d;
      mis_pend_q   <= mis_pend_d;
      halt_after_q <= halt_after_d;
    end
  end

  assign fifo_push = push & ~fifo_full;
  assign fifo_pop  = if_valid & if_ready;

  core_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_entry)
  );

  assign if_valid = ~fifo_empty;
  assign if_instr = fifo_empty ? 32'h0 : head_entry.instr;
  assign if_pc    = fifo_empty ? 32'h0 : head_entry.pc;
  assign if_exc   = fifo_empty ? FEXC_NONE : head_entry.exc;

endmodule

// File: doc/core_fetch.md
CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  core clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  fetch request accepted.
REQ-007 SHALL have port imem_req_addr  output  32  fetch address, word-aligned.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid, always accepted.
REQ-009 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-010 SHALL have port imem_rsp_err  input  1  access fault for this response.
REQ-011 SHALL have port redirect_valid  input  1  redirect request from a branch, jump or trap.
REQ-012 SHALL have port redirect_pc  input  32  redirect target.
REQ-013 SHALL have port if_valid  output  1  instruction available to the decoder.
REQ-014 SHALL have port if_ready  input  1  decoder consumes this cycle.
REQ-015 SHALL have port if_instr  output  32  instruction word, which feeds the immediate parser and decoder.
REQ-016 SHALL have port if_pc  output  32  PC of if_instr.
REQ-017 SHALL have port if_exc  output  core_pkg::fetch_exc_e  fetch exception: FEXC_NONE, FEXC_MISALIGNED or FEXC_ACCESS.

Function
REQ-018 SHALL keep at most one accepted request outstanding, with its response arriving no earlier than the cycle after acceptance.
REQ-019 SHALL assert imem_req_valid only when all of these hold: not halted, no response outstanding (or the outstanding response arrives this cycle), and the FIFO count plus pending responses is less than FIFO_DEPTH.
REQ-020 SHALL hold imem_req_valid and imem_req_addr stable once asserted until the handshake completes, and SHALL hold them stable even on redirect.
REQ-021 SHALL advance fetch_pc by 4 on each request handshake, using modulo-2^32 wrap-around.
REQ-022 SHALL push {data, pc, exc} to the FIFO on imem_rsp_valid unless the response is marked discard; FEXC_ACCESS SHALL be pushed when imem_rsp_err=1.
REQ-023 SHALL set if_valid whenever the FIFO is non-empty, and SHALL drive if_instr, if_pc and if_exc from the head entry.
REQ-024 SHALL pop on the cycle where if_valid and if_ready are both high.
REQ-025 SHALL make a pushed entry visible on if_valid no earlier than the next cycle, with no combinational response-to-output path.
REQ-026 SHALL process redirect_valid with highest priority: flush the FIFO, set fetch_pc to redirect_pc, clear the halt, and mark any outstanding or unaccepted-but-asserted request as discard.
REQ-027 SHALL win over a same-cycle push or pop on redirect, so that the FIFO is empty in the next cycle.
REQ-028 SHALL respond to a redirect with redirect_pc[1:0]!=0 by issuing no bus request, pushing one entry {instr 0, pc redirect_pc, FEXC_MISALIGNED} once the FIFO is empty, and then halting.
REQ-029 SHALL halt after pushing any FEXC_ACCESS entry, issuing no requests until the next redirect.
REQ-030 SHALL use FSM states FETCH, WAIT_RSP, DISCARD and HALT. FETCH goes to WAIT_RSP on handshake. WAIT_RSP goes to FETCH on response, or to HALT on an error response. Any state goes to DISCARD on redirect while a request is outstanding or asserted. DISCARD goes to FETCH when the discarded response arrives.
REQ-031 SHALL let FETCH go straight to HALT on a misaligned redirect when nothing is outstanding.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, set fetch_pc=RESET_VEC, empty the FIFO, clear the outstanding and discard tracking, and enter state FETCH.
REQ-033 SHALL drive these output values during and directly after reset: imem_req_valid=0 during reset, imem_req_addr=RESET_VEC, if_valid=0, if_instr=0, if_pc=0, if_exc=FEXC_NONE.
REQ-034 SHALL assert imem_req_valid with RESET_VEC in the first cycle after rst_n rises.
REQ-035 SHALL abandon any in-flight response on a reset mid-operation, since the memory is reset in the same domain.

Structure
REQ-036 SHALL declare fetch_exc_e and the fetch FSM state enum in core_pkg.
REQ-037 SHALL implement the buffer as sub-module core_fetch_fifo with push, pop, flush, full, empty and count ports, parameterised by FIFO_DEPTH.

Verification
REQ-038 Reset release with zero-wait memory: a request to 0x8000_0000 SHALL be issued in cycle 1, with if_valid, if_pc=0x8000_0000 and if_instr set to the returned word two cycles later.
REQ-039 Back-to-back fetch with if_ready held low: requests SHALL stop once 2 entries are buffered, and the PCs SHALL be 0x8000_0000 and 0x8000_0004 with no drops.
REQ-040 Redirect to 0x100 while a response is outstanding: the stale response SHALL be discarded, and the next if_pc SHALL be 0x100.
REQ-041 Redirect to 0x102: if_exc SHALL be FEXC_MISALIGNED and if_pc SHALL be 0x102, with no bus request until the next redirect.
REQ-042 Response with imem_rsp_err=1 at PC 0x8000_0008: if_exc SHALL be FEXC_ACCESS, followed by a halt, and a redirect to 0x200 SHALL resume fetching.
REQ-043 fetch_pc=0xFFFF_FFFC: the fetch after it SHALL use address 0x0000_0000.
